// File: rtl/reg_bank_mp.sv
// General-purpose register bank: decoded bus-side read/write port, registered
// second read port with write-forwarding, and a per-register pending-write scoreboard.
module reg_bank_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RA_LSB   = 23,
    parameter int unsigned RB_LSB   = 19,
    parameter int unsigned RC_LSB   = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         ir,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic [DATA_W-1:0]   bus_in,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_drive,
    input  logic                reserve,
    output logic                hazard,
    input  logic [ADDR_W-1:0]   rb_addr,
    output logic [DATA_W-1:0]   rb_data,
    output logic [NUM_REGS-1:0] pending
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0]   sel;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    rb_idx;
    logic                rb_valid;
    logic                wr_en;
    logic                res_en;
    logic [NUM_REGS-1:0] sel_dec;
    logic [DATA_W-1:0]   sel_data;

    // Register-field decode with fixed priority gra > grb > grc
    always_comb begin
        sel = '0;
        if (gra)
            sel = ir[RA_LSB +: ADDR_W];
        else if (grb)
            sel = ir[RB_LSB +: ADDR_W];
        else if (grc)
            sel = ir[RC_LSB +: ADDR_W];
    end

    assign sel_valid = (gra | grb | grc) && (32'(sel) < NUM_REGS);
    assign sel_idx   = IDX_W'(sel);
    assign rb_valid  = 32'(rb_addr) < NUM_REGS;
    assign rb_idx    = IDX_W'(rb_addr);
    assign wr_en     = rin & sel_valid;
    assign res_en    = reserve & sel_valid;
    assign sel_dec   = sel_valid ? (NUM_REGS'(1) << sel_idx) : '0;
    assign sel_data  = sel_valid ? regs[sel_idx] : '0;

    // Port A: zero when idle so it can be OR-ed onto the shared bus
    assign bus_drive = (rout | baout) & sel_valid;
    assign bus_out   = (bus_drive && !(baout && sel == '0)) ? sel_data : '0;
    assign hazard    = bus_drive & |(pending & sel_dec);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[sel_idx] <= bus_in;
        end
    end

    // Port B with forwarding of a same-edge write
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            rb_data <= '0;
        else if (!rb_valid)
            rb_data <= '0;
        else if (wr_en && sel == rb_addr)
            rb_data <= bus_in;
        else
            rb_data <= regs[rb_idx];
    end

    // Scoreboard: a write clears its bit, a reservation on the same edge wins
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            pending <= '0;
        else
            pending <= (pending & ~(wr_en ? sel_dec : '0)) | (res_en ? sel_dec : '0);
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp, built with NUM_REGS=12 so that
// out-of-range indices are exercised alongside the normal datapath.
module tb_reg_bank_mp;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 12;
    localparam int unsigned ADDR_W   = 4;

    logic                clock = 1'b0;
    logic                clear;
    logic [31:0]         ir;
    logic                gra, grb, grc, rin, rout, baout, reserve;
    logic [DATA_W-1:0]   bus_in;
    logic [DATA_W-1:0]   bus_out;
    logic                bus_drive;
    logic                hazard;
    logic [ADDR_W-1:0]   rb_addr;
    logic [DATA_W-1:0]   rb_data;
    logic [NUM_REGS-1:0] pending;

    int total = 0;
    int fails = 0;

    reg_bank_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .RA_LSB(23), .RB_LSB(19), .RC_LSB(15)
    ) dut (
        .clock(clock), .clear(clear), .ir(ir),
        .gra(gra), .grb(grb), .grc(grc),
        .rin(rin), .rout(rout), .baout(baout),
        .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
        .reserve(reserve), .hazard(hazard),
        .rb_addr(rb_addr), .rb_data(rb_data), .pending(pending)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [3:0] rc);
        logic [31:0] w;
        w        = '0;
        w[26:23] = ra;
        w[22:19] = rb;
        w[18:15] = rc;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0; reserve = 0;
    endtask

    initial begin
        clear = 1'b1; ir = '0; bus_in = '0; rb_addr = '0;
        idle();
        #2;
        chk("reset_rb_data", rb_data, 32'h0);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_bus_out", bus_out, 32'h0);
        #10 clear = 1'b0;

        // Write R5 through Ra, read back on port A
        ir = mk_ir(5, 0, 0); gra = 1; rin = 1; bus_in = 32'hDEADBEEF;
        tick();
        rin = 0; rout = 1; #1;
        chk("r5_bus_out", bus_out, 32'hDEADBEEF);
        chk("r5_bus_drive", 32'(bus_drive), 32'h1);
        chk("r5_hazard", 32'(hazard), 32'h0);
        idle();

        // R0 zeroing under baout
        ir = mk_ir(0, 0, 0); gra = 1; rin = 1; bus_in = 32'h1234;
        tick();
        rin = 0; baout = 1; #1;
        chk("r0_baout_out", bus_out, 32'h0);
        chk("r0_baout_drive", 32'(bus_drive), 32'h1);
        baout = 0; rout = 1; #1;
        chk("r0_rout_out", bus_out, 32'h1234);
        baout = 1; #1;
        chk("r0_both_out", bus_out, 32'h0);
        idle();

        // Priority gra over grb; port B latency
        ir = mk_ir(3, 7, 0); gra = 1; grb = 1; rin = 1; bus_in = 32'hA5;
        tick();
        rin = 0; rb_addr = 3;
        tick();
        chk("prio_rb_r3", rb_data, 32'hA5);
        gra = 0; rout = 1; #1;
        chk("prio_r7_unchanged", bus_out, 32'h0);
        idle();

        // Forwarding and out-of-range read
        ir = mk_ir(9, 0, 0); gra = 1; rin = 1; bus_in = 32'h55; rb_addr = 9;
        tick();
        chk("fwd_rb_r9", rb_data, 32'h55);
        rin = 0; rb_addr = 15;
        tick();
        chk("oob_rb_r15", rb_data, 32'h0);
        ir = mk_ir(13, 0, 0); rin = 1; bus_in = 32'h99;
        tick();
        rin = 0; rout = 1; #1;
        chk("oob_sel_drive", 32'(bus_drive), 32'h0);
        chk("oob_sel_out", bus_out, 32'h0);
        idle();

        // Scoreboard on R4 via Rc
        ir = mk_ir(0, 0, 4); grc = 1; reserve = 1;
        tick();
        reserve = 0;
        chk("sb_reserve", 32'(pending), 32'h010);
        rout = 1; #1;
        chk("sb_hazard_set", 32'(hazard), 32'h1);
        rout = 0; rin = 1; reserve = 1; bus_in = 32'h77;
        tick();
        chk("sb_reserve_wins", 32'(pending), 32'h010);
        reserve = 0;
        tick();
        rin = 0;
        chk("sb_write_clears", 32'(pending), 32'h0);
        rout = 1; #1;
        chk("sb_hazard_clr", 32'(hazard), 32'h0);
        chk("sb_r4_data", bus_out, 32'h77);
        idle();

        // Hazard under baout of R0
        ir = mk_ir(0, 0, 0); gra = 1; reserve = 1;
        tick();
        reserve = 0; baout = 1; #1;
        chk("r0_hazard", 32'(hazard), 32'h1);
        idle();

        // Asynchronous clear between edges
        ir = mk_ir(2, 6, 0); gra = 1; rin = 1; bus_in = 32'hFF;
        tick();
        gra = 0; grb = 1; rin = 0; reserve = 1;
        tick();
        reserve = 0; rb_addr = 2;
        tick();
        chk("pre_clr_rb", rb_data, 32'hFF);
        chk("pre_clr_pending", 32'(pending), 32'h041);
        idle();
        #2 clear = 1'b1;
        #1;
        chk("clr_rb_data", rb_data, 32'h0);
        chk("clr_pending", 32'(pending), 32'h0);
        gra = 1; rout = 1; #1;
        chk("clr_r2", bus_out, 32'h0);
        #3 clear = 1'b0;
        tick();
        chk("post_clr_rb", rb_data, 32'h0);
        chk("post_clr_r2", bus_out, 32'h0);
        idle();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
